// File: rtl/display_dec_scan.sv
// display_dec_scan: binary-to-decimal converter (sequential shift-add-3) feeding
// GROUPS banks of 4-digit multiplexed 7-segment displays, with leading-zero
// blanking, overflow dashes and a freeze/commit handshake.
module display_dec_scan #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned GROUPS   = 2,
    parameter int unsigned SCAN_DIV = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_en,
    input  logic                  freeze,
    output logic [12*GROUPS-1:0]  seg_out,
    output logic                  busy,
    output logic                  conv_done,
    output logic                  overflow
);

    localparam int unsigned NDIG = 4 * GROUPS;
    localparam int unsigned BCDW = 4 * NDIG;
    localparam int unsigned CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PREW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    shift_q;
    logic [BCDW-1:0]     bcd_q;
    logic                ovf_sticky_q;
    logic [CNTW-1:0]     cnt_q;
    logic [BCDW-1:0]     disp_q;
    logic                ovf_q;
    logic                busy_q;
    logic                conv_done_q;

    logic [PREW-1:0]     pre_q;
    logic [1:0]          idx_q;
    logic [1:0]          idx_d;
    logic                pre_wrap;
    logic [12*GROUPS-1:0] seg_q;
    logic [12*GROUPS-1:0] seg_d;

    logic [BCDW-1:0]     bcd_adj;
    logic [BCDW-1:0]     bcd_d;
    logic [WIDTH-1:0]    shift_d;
    logic                carry_out;

    logic [NDIG:0]       zero_above;
    int unsigned         pos;
    logic [3:0]          dig;
    logic [7:0]          code;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // One shift-add-3 step: adjust every nibble >= 5, then shift {bcd, shift} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d     = {bcd_adj[BCDW-2:0], shift_q[WIDTH-1]};
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        carry_out = bcd_adj[BCDW-1];
    end

    // Converter FSM with registered busy / conv_done / overflow and display digits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bcd_q        <= '0;
            ovf_sticky_q <= 1'b0;
            cnt_q        <= '0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            conv_done_q  <= 1'b0;
        end else begin
            conv_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    shift_q      <= value;
                    bcd_q        <= '0;
                    ovf_sticky_q <= 1'b0;
                    cnt_q        <= '0;
                    busy_q       <= 1'b1;
                    state_q      <= ST_CONV;
                end
                ST_CONV: begin
                    bcd_q   <= bcd_d;
                    shift_q <= shift_d;
                    if (carry_out) begin
                        ovf_sticky_q <= 1'b1;
                    end
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_COMMIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (!freeze) begin
                        disp_q      <= bcd_q;
                        ovf_q       <= ovf_sticky_q;
                        conv_done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Next slot index; the segment register samples the new slot on the wrap edge.
    always_comb begin
        pre_wrap = (pre_q == PREW'(SCAN_DIV - 1));
        idx_d    = pre_wrap ? idx_q + 2'd1 : idx_q;
    end

    // Per-lane digit selection, blanking and overflow dashes for the next slot.
    always_comb begin
        zero_above       = '0;
        zero_above[NDIG] = 1'b1;
        for (int unsigned i = NDIG; i > 0; i--) begin
            zero_above[i-1] = zero_above[i] & (disp_q[4*(i-1) +: 4] == 4'd0);
        end
        seg_d = '0;
        pos   = 0;
        dig   = '0;
        code  = '0;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            pos = 4*g + 3 - 32'(idx_d);
            dig = disp_q[4*pos +: 4];
            if (ovf_q) begin
                code = 8'h02;
            end else if (blank_en && (pos != 0) && zero_above[pos]) begin
                code = '0;
            end else begin
                code = seg7(dig);
            end
            seg_d[12*g +: 12] = {4'b1000 >> idx_d, code};
        end
    end

    // Scan prescaler, slot index and registered segment lanes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= '0;
        end else begin
            pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
            idx_q <= idx_d;
            seg_q <= seg_d;
        end
    end

    assign seg_out   = seg_q;
    assign busy      = busy_q;
    assign conv_done = conv_done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_display_dec_scan.sv
// Self-checking bench for display_dec_scan: directed scenarios plus random
// values, all compared every cycle against a decimal-arithmetic reference model.
module tb_display_dec_scan;

    localparam int W = 32;
    localparam int G = 2;
    localparam int S = 4;
    localparam int P = W + 2;
    localparam longint LIMIT = 100000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value = '0;
    logic        blank_en = 1'b0;
    logic        freeze = 1'b0;
    logic [23:0] seg_out;
    logic        busy;
    logic        conv_done;
    logic        overflow;

    display_dec_scan #(.WIDTH(W), .GROUPS(G), .SCAN_DIV(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .blank_en  (blank_en),
        .freeze    (freeze),
        .seg_out   (seg_out),
        .busy      (busy),
        .conv_done (conv_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] SEG [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    function automatic longint pow10(input int k);
        longint p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // Expected lanes for a displayed decimal value in a given slot.
    function automatic logic [23:0] model_seg(input longint v, input bit ov,
                                              input bit bl, input int s);
        logic [23:0] r;
        logic [3:0]  sel;
        logic [7:0]  c;
        longint      p;
        int          k;
        int          d;
        r   = '0;
        sel = 4'b1000 >> s;
        for (int g = 0; g < G; g++) begin
            k = 4*g + 3 - s;
            p = pow10(k);
            d = int'((v / p) % 10);
            if (ov)                      c = 8'h02;
            else if (bl && k > 0 && v < p) c = 8'h00;
            else                         c = SEG[d];
            r[12*g +: 12] = {sel, c};
        end
        return r;
    endfunction

    // Reference model: conversions start every P cycles after reset release.
    int unsigned ncyc = 0;
    longint      lat = 0;
    longint      shown = 0;
    bit          shown_ovf = 0;
    logic [23:0] exp_seg = '0;
    bit          exp_done = 0;
    bit          exp_busy = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncyc      <= 0;
            lat       <= 0;
            shown     <= 0;
            shown_ovf <= 0;
            exp_seg   <= '0;
            exp_done  <= 0;
            exp_busy  <= 0;
        end else begin
            ncyc     <= ncyc + 1;
            exp_seg  <= model_seg(shown, shown_ovf, blank_en, int'(((ncyc + 1) / S) % 4));
            exp_done <= ((ncyc + 1) % P == 0) && !freeze;
            exp_busy <= ((ncyc + 1) % P != 0);
            if ((ncyc + 1) % P == 1) lat <= {32'd0, value};
            if ((ncyc + 1) % P == 0 && !freeze) begin
                shown     <= lat;
                shown_ovf <= (lat >= LIMIT);
            end
        end
    end

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_seg", {8'd0, seg_out}, {8'd0, exp_seg});
            check("mon_busy", {31'd0, busy}, {31'd0, exp_busy});
            check("mon_done", {31'd0, conv_done}, {31'd0, exp_done});
            check("mon_ovf", {31'd0, overflow}, {31'd0, shown_ovf});
        end
    end

    task automatic expect_display(input string tag, input logic [31:0] up, input logic [31:0] lo);
        int s;
        logic [31:0] u;
        logic [31:0] l;
        u = up;
        l = lo;
        repeat (4*S) begin
            @(negedge clk);
            s = int'((ncyc / S) % 4);
            check({tag, "_up"}, {20'd0, seg_out[23:12]}, {20'd0, 4'b1000 >> s, u[31-8*s -: 8]});
            check({tag, "_lo"}, {20'd0, seg_out[11:0]},  {20'd0, 4'b1000 >> s, l[31-8*s -: 8]});
        end
    endtask

    task automatic wait_done(input string tag, input int limit, output int cyc);
        bit seen = 0;
        cyc = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (conv_done) seen = 1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int run;
        logic [3:0] prev;
        int digs;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", {8'd0, seg_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, conv_done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: plain digits
        value = 32'd12345678;
        blank_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1;
        step(70);
        expect_display("t1", 32'h60DAF266, 32'hB6BEE0FE);
        wait_done("t1a", 100, c);
        wait_done("t1b", 100, c);
        check("t1_period", c, P);

        // 2: blanking
        value = 32'd42;
        blank_en = 1'b1;
        step(2*P + 2);
        expect_display("t2", 32'h00000000, 32'h000066DA);
        value = 32'd0;
        step(2*P + 2);
        expect_display("t2z", 32'h00000000, 32'h000000FC);

        // 3: overflow boundary
        value = 32'd100000000;
        step(2*P + 2);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        expect_display("t3", 32'h02020202, 32'h02020202);
        value = 32'd99999999;
        step(2*P + 2);
        check("t3_noovf", {31'd0, overflow}, 32'd0);
        expect_display("t3n", 32'hF6F6F6F6, 32'hF6F6F6F6);

        // 4: freeze
        blank_en = 1'b0;
        value = 32'd1234;
        step(2*P + 2);
        expect_display("t4", 32'hFCFCFCFC, 32'h60DAF266);
        freeze = 1'b1;
        value = 32'd9;
        run = 0;
        repeat (3*P) begin
            @(negedge clk);
            if (conv_done) run++;
        end
        check("t4_frozen_done", run, 0);
        expect_display("t4f", 32'hFCFCFCFC, 32'h60DAF266);
        @(posedge clk); #1;
        freeze = 1'b0;
        wait_done("t4r", 2*P, c);
        expect_display("t4r", 32'hFCFCFCFC, 32'hFCFCFCF6);

        // 5: reset in the middle of a conversion
        value = 32'd87654321;
        c = 0;
        while ((ncyc % P) != 10 && c < 2*P) begin
            @(negedge clk);
            c++;
        end
        #1 reset = 1'b0;
        #1;
        check("t5_seg", {8'd0, seg_out}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, conv_done}, 32'd0);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_done("t5", 100, c);
        check("t5_first_done", c, P);
        expect_display("t5", 32'hFEE0BEB6, 32'h66F2DA60);

        // 6: scan cadence
        prev = seg_out[23:20];
        run = 0;
        for (int i = 0; i < 16*S + S; i++) begin
            @(negedge clk);
            check("t6_sel_up", {28'd0, seg_out[23:20]}, {28'd0, 4'b1000 >> ((ncyc / S) % 4)});
            check("t6_sel_lo", {28'd0, seg_out[11:8]},  {28'd0, 4'b1000 >> ((ncyc / S) % 4)});
            if (seg_out[23:20] == prev) begin
                run++;
            end else begin
                if (run > 0 && i > S) check("t6_slot_len", run, S);
                run = 1;
                prev = seg_out[23:20];
            end
        end

        // random values, blanking and occasional freeze
        for (int i = 0; i < 30; i++) begin
            digs = int'($urandom_range(0, 10));
            if (digs == 10) value = $urandom;
            else value = 32'($urandom % 32'(pow10(digs)));
            blank_en = 1'($urandom_range(0, 1));
            freeze = ($urandom_range(0, 3) == 0);
            step(int'($urandom_range(5, 80)));
        end
        freeze = 1'b0;
        step(2*P + 4);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
